// File: rtl/button_pkg.sv
// Shared types and default timing constants for the pushbutton debouncer.
// Long-press detection is built only when LONG_PRESS_EN is defined.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } db_state_t;

    // 10 ms and 1 s at a 12 MHz system clock
    localparam int DEBOUNCE_CYCLES_DEF   = 120000;
    localparam int LONG_PRESS_CYCLES_DEF = 12000000;

    // True in the states where the accepted level is "pressed"
    function automatic logic is_held(input db_state_t s);
        return (s == PRESSED) || (s == RELEASE_PEND);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; synchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Pushbutton debouncer: synchronizer, 4-state stability FSM, press/release strobes.
// Define LONG_PRESS_EN to build the hold counter and long_press strobe.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_raw,
    output logic button_db,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int STAB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);

    if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 16777215)
        || (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES)) begin : g_bad_cfg
        $error("button_debounce: illegal DEBOUNCE_CYCLES/LONG_PRESS_CYCLES");
    end

    logic btn_s;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (button_raw),
        .q     (btn_s)
    );

    db_state_t         state_q, state_d;
    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic              button_db_q, button_db_d;
    logic              press_pulse_q, press_pulse_d;
    logic              release_pulse_q, release_pulse_d;

    // The counter only runs while a pending level stays put; any state change clears it.
    always_comb begin
        state_d         = state_q;
        stab_cnt_d      = stab_cnt_q;
        button_db_d     = button_db_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (btn_s) begin
                    state_d    = PRESS_PEND;
                    stab_cnt_d = '0;
                end
            end
            PRESS_PEND: begin
                if (!btn_s) begin
                    state_d    = RELEASED;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d       = PRESSED;
                    stab_cnt_d    = '0;
                    button_db_d   = 1'b1;
                    press_pulse_d = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + STAB_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d    = RELEASE_PEND;
                    stab_cnt_d = '0;
                end
            end
            RELEASE_PEND: begin
                if (btn_s) begin
                    state_d    = PRESSED;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d         = RELEASED;
                    stab_cnt_d      = '0;
                    button_db_d     = 1'b0;
                    release_pulse_d = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + STAB_W'(1);
                end
            end
            default: begin
                state_d    = RELEASED;
                stab_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= RELEASED;
            stab_cnt_q      <= '0;
            button_db_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            stab_cnt_q      <= stab_cnt_d;
            button_db_q     <= button_db_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
        end
    end

    assign button_db     = button_db_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

`ifdef LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_done_q, long_done_d;
    logic              long_press_q, long_press_d;

    // Restart only on an accepted press, so a release glitch does not reset the hold time;
    // the counter then saturates and long_done blocks a repeat strobe.
    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        long_done_d  = long_done_q;
        long_press_d = 1'b0;
        if (press_pulse_d) begin
            hold_cnt_d  = '0;
            long_done_d = 1'b0;
        end else if (is_held(state_q)) begin
            if (hold_cnt_q == HOLD_LAST) begin
                if (!long_done_q) begin
                    long_press_d = 1'b1;
                    long_done_d  = 1'b1;
                end
            end else begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt_q   <= '0;
            long_done_q  <= 1'b0;
            long_press_q <= 1'b0;
        end else begin
            hold_cnt_q   <= hold_cnt_d;
            long_done_q  <= long_done_d;
            long_press_q <= long_press_d;
        end
    end

    assign long_press = long_press_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce with DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32.
// Long-press expectations follow whether LONG_PRESS_EN is defined for the build.
module tb_button_debounce;

    localparam int DB = 8;
    localparam int LP = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic button_raw = 1'b0;
    logic button_db, press_pulse, release_pulse, long_press;

    int total = 0;
    int bad = 0;
    int pulse_violations = 0;
    logic prev_pulse = 1'b0;

    always #5 clk = ~clk;

    button_debounce #(
        .DEBOUNCE_CYCLES   (DB),
        .LONG_PRESS_CYCLES (LP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .button_raw    (button_raw),
        .button_db     (button_db),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    // Press and release strobes must never coincide or sit on adjacent cycles
    always @(negedge clk) begin
        if (press_pulse && release_pulse) pulse_violations++;
        if (prev_pulse && (press_pulse || release_pulse)) pulse_violations++;
        prev_pulse = press_pulse || release_pulse;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive inputs one time unit after an edge, then advance to just after the next edge
    task automatic applyStimulus(input logic raw, input logic rstn);
        button_raw = raw;
        rst_n      = rstn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n_press, n_release, n_long, long_k, n_db_low, n_db_high;

        $display("[TB] reset state");
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("reset button_db", button_db, 0);
        checkOutput("reset press_pulse", press_pulse, 0);
        checkOutput("reset release_pulse", release_pulse, 0);
        checkOutput("reset long_press", long_press, 0);
        repeat (4) applyStimulus(1'b0, 1'b1);

        $display("[TB] clean press");
        for (int k = 0; k <= 11; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("press db k=%0d", k), button_db, (k >= 10) ? 1 : 0);
            checkOutput($sformatf("press pulse k=%0d", k), press_pulse, (k == 10) ? 1 : 0);
        end

        $display("[TB] long hold");
        n_press = 0; n_release = 0; n_long = 0; long_k = -1;
        for (int k = 12; k <= 110; k++) begin
            applyStimulus(1'b1, 1'b1);
            if (press_pulse) n_press++;
            if (release_pulse) n_release++;
            if (long_press) begin
                n_long++;
                long_k = k;
            end
        end
        checkOutput("hold button_db", button_db, 1);
        checkOutput("hold extra press", n_press, 0);
        checkOutput("hold release", n_release, 0);
`ifdef LONG_PRESS_EN
        checkOutput("long_press count", n_long, 1);
        checkOutput("long_press cycle", long_k, 10 + LP);
`else
        checkOutput("long_press count", n_long, 0);
`endif

        $display("[TB] release glitch while pressed");
        n_press = 0; n_release = 0; n_db_low = 0; n_long = 0;
        for (int k = 0; k < 27; k++) begin
            applyStimulus((k < DB - 1) ? 1'b0 : 1'b1, 1'b1);
            if (press_pulse) n_press++;
            if (release_pulse) n_release++;
            if (!button_db) n_db_low++;
            if (long_press) n_long++;
        end
        checkOutput("glitch db low cycles", n_db_low, 0);
        checkOutput("glitch release", n_release, 0);
        checkOutput("glitch press", n_press, 0);
        checkOutput("glitch long repeat", n_long, 0);

        $display("[TB] clean release");
        for (int k = 0; k <= 11; k++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("release db k=%0d", k), button_db, (k < 10) ? 1 : 0);
            checkOutput($sformatf("release pulse k=%0d", k), release_pulse, (k == 10) ? 1 : 0);
        end

        $display("[TB] bounce rejection");
        n_press = 0; n_release = 0; n_db_high = 0;
        for (int k = 0; k < 60; k++) begin
            applyStimulus((k < 40 && ((k / 3) % 2 == 0)) ? 1'b1 : 1'b0, 1'b1);
            if (press_pulse) n_press++;
            if (release_pulse) n_release++;
            if (button_db) n_db_high++;
        end
        checkOutput("bounce db high cycles", n_db_high, 0);
        checkOutput("bounce press", n_press, 0);
        checkOutput("bounce release", n_release, 0);

        $display("[TB] reset mid-debounce");
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("in reset outputs k=%0d", k),
                        {button_db, press_pulse, release_pulse, long_press}, 0);
        end
        for (int k = 0; k <= 11; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("post-reset db k=%0d", k), button_db, (k >= 10) ? 1 : 0);
            checkOutput($sformatf("post-reset pulse k=%0d", k), press_pulse, (k == 10) ? 1 : 0);
        end

        checkOutput("pulse spacing violations", pulse_violations, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 120000, is the number of consecutive stable samples needed to accept a level change (10 ms at 12 MHz); legal range 2 to 2^24-1.
REQ-002 Parameter LONG_PRESS_CYCLES, default 12000000, is the number of held cycles after an accepted press before long_press fires (1 s at 12 MHz); must exceed DEBOUNCE_CYCLES.
REQ-003 clk  input  1  is the single system clock (12 MHz); all flops are rising-edge.
REQ-004 rst_n  input  1  is the reset: synchronous, active-low.
REQ-005 button_raw  input  1  is the asynchronous, bouncy pushbutton, active-high (1 = pressed).
REQ-006 button_db  output  1  is the debounced level, registered; it feeds the LED version-flash block's button input.
REQ-007 press_pulse  output  1  is a one-cycle strobe on an accepted press.
REQ-008 release_pulse  output  1  is a one-cycle strobe on an accepted release.
REQ-009 long_press  output  1  is a one-cycle strobe after a sustained hold.

Function
REQ-010 button_raw SHALL pass through a 2-flop synchronizer; the second stage, btn_s, is the only signal the FSM samples.
REQ-011 The FSM SHALL have states RELEASED, PRESS_PEND, PRESSED and RELEASE_PEND.
REQ-012 RELEASED SHALL move to PRESS_PEND when btn_s=1, clearing stab_cnt.
REQ-013 In PRESS_PEND, btn_s=0 SHALL return the FSM to RELEASED (bounce rejected); otherwise stab_cnt SHALL increment.
REQ-014 When stab_cnt==DEBOUNCE_CYCLES-1 with btn_s=1, PRESS_PEND SHALL go to PRESSED, and in that same edge button_db SHALL be set to 1 and press_pulse asserted for one cycle.
REQ-015 PRESSED, RELEASE_PEND and the return to RELEASED SHALL mirror REQ-012 to REQ-014, with release_pulse in place of press_pulse and button_db cleared.
REQ-016 Latency SHALL be exact: a clean step on button_raw changes button_db on the (DEBOUNCE_CYCLES+2)th rising edge after the first edge that samples the new level.
REQ-017 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave button_db, press_pulse and release_pulse unchanged.
REQ-018 press_pulse and release_pulse SHALL never be high in the same cycle and SHALL never be high on consecutive cycles.
REQ-019 stab_cnt SHALL be $clog2(DEBOUNCE_CYCLES) bits wide, SHALL never wrap, and SHALL be cleared on every state change.
REQ-020 button_db SHALL change only on PRESS_PEND->PRESSED and RELEASE_PEND->RELEASED transitions.

Reset
REQ-021 With rst_n=0 at a rising edge, the synchronizer flops, FSM (RELEASED), stab_cnt, hold_cnt, button_db, press_pulse, release_pulse and long_press SHALL all be cleared to 0.
REQ-022 If the button is held through reset release, it SHALL be debounced as a fresh press; no pulse SHALL be emitted during reset.
REQ-023 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no pulse.

Configuration
REQ-024 Macro LONG_PRESS_EN defined: hold_cnt, $clog2(LONG_PRESS_CYCLES) bits, SHALL clear when the FSM enters PRESSED and increment in PRESSED and RELEASE_PEND.
REQ-025 Macro LONG_PRESS_EN defined: long_press SHALL pulse once when hold_cnt==LONG_PRESS_CYCLES-1; hold_cnt SHALL then saturate with no repeat until the next accepted press.
REQ-026 Macro LONG_PRESS_EN undefined: hold_cnt SHALL be absent and long_press SHALL be tied to 0; the port list SHALL be unchanged.

Structure
REQ-027 Package button_pkg SHALL hold the FSM state enum typedef (db_state_t) and the default constants DEBOUNCE_CYCLES_DEF and LONG_PRESS_CYCLES_DEF.
REQ-028 The synchronizer SHALL be sub-module sync_2ff (ports clk, rst_n, d, q), reusable for other async inputs.

Verification
REQ-029 Clean press: DEBOUNCE_CYCLES=8; raise button_raw at cycle 0 and hold -> button_db rises and press_pulse=1 for exactly 1 cycle at cycle 10.
REQ-030 Bounce rejection: toggle button_raw 1/0 with 3-cycle periods for 40 cycles, then hold 0 -> button_db stays 0 and no pulses occur.
REQ-031 Release: from pressed, drop button_raw and hold -> button_db falls and release_pulse=1 for 1 cycle, 10 cycles later.
REQ-032 Long press with LONG_PRESS_EN, LONG_PRESS_CYCLES=32: hold for 100 cycles -> exactly one long_press pulse, 32 cycles after press_pulse; build without the macro -> long_press always 0.
REQ-033 Reset mid-debounce: raise button_raw, assert rst_n=0 at cycle 5 for 3 cycles while holding button_raw=1 -> all outputs 0 during reset; press_pulse fires 10 cycles after rst_n returns high.
